// File: rtl/noc_tb_pkg.sv
// noc_tb_pkg: shared flit format and injector state types
// for the NoC traffic sources and monitors.
package noc_tb_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } inj_state_e;

  localparam int TYPE_W  = 2;
  localparam int IDX_LSB = 0;
  localparam int IDX_W   = 16;
  localparam int SEQ_LSB = IDX_LSB + IDX_W;
  localparam int MIN_DW  = SEQ_LSB + TYPE_W;

  function automatic flit_type_e flit_type(
    input logic first,
    input logic last
  );
    flit_type_e t;
    t = FT_BODY;
    unique case (1'b1)
      first && last:   t = FT_SINGLE;
      first && !last:  t = FT_HEAD;
      !first && last:  t = FT_TAIL;
      default:         t = FT_BODY;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/injector_credit_counter.sv
// credit_counter: saturating transmit credit pool,
// +1 on receiver credit return, -1 on flit issue.
module credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(CREDITS+1)-1:0] count,
  output logic                         avail
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = count;
    unique case ({inc, dec})
      2'b10: begin
        // a return while full is a receiver bug; hold at max
        if (count != CMAX)
          cnt_nxt = count + 1'b1;
      end
      2'b01: cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      count <= CMAX;
    else
      count <= cnt_nxt;
  end

  assign avail = (count != '0);

endmodule

// File: rtl/injector.sv
// injector: credit-flow-controlled packet source for one NoC port.
// Define INJECTOR_TRACE_EN to trace each issued flit for send_pool_<id>.
`ifndef DW
`define DW 32
`endif
`ifndef BUFFER_ALLOC
`define BUFFER_ALLOC 4
`endif

module injector #(
  parameter string id      = "0",
  parameter int    DW      = `DW,
  parameter int    CREDITS = `BUFFER_ALLOC,
  parameter int    NUM_PKT = 198,
  parameter int    PKT_LEN = 5,
  parameter int    GAP     = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          valid,
  output logic [DW-1:0] data,
  input  logic          credit_upd,
  output logic          done,
  output logic [31:0]   sent_cnt
);

  import noc_tb_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  inj_state_e     state;
  inj_state_e     state_nxt;
  logic [CW-1:0]  credit_cnt;
  logic           avail;
  logic           issue;
  logic [IDX_W-1:0] idx;
  logic [31:0]    seq;
  logic [31:0]    gap_cnt;
  logic           last_flit;
  logic           last_pkt;
  logic           gap_end;
  logic [DW-1:0]  flit;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_cc (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (credit_upd),
    .dec   (issue),
    .count (credit_cnt),
    .avail (avail)
  );

  assign issue     = (state == ST_SEND) && avail;
  assign last_flit = (idx == IDX_W'(PKT_LEN - 1));
  assign last_pkt  = (seq == 32'(NUM_PKT - 1));
  assign gap_end   = (gap_cnt == 32'(GAP_LAST));

  // seq and idx are truncated together so seq wraps at its field width
  always_comb begin
    flit = {flit_type(idx == '0, last_flit),
            (DW-TYPE_W)'({seq, idx})};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (issue && last_flit) begin
          if (last_pkt)
            state_nxt = ST_DONE;
          else if (GAP > 0)
            state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end)
          state_nxt = ST_SEND;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      data     <= '0;
      done     <= 1'b0;
      sent_cnt <= '0;
      idx      <= '0;
      seq      <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      valid <= issue;
      done  <= done | (state == ST_DONE);
      if (issue) begin
        data     <= flit;
        sent_cnt <= sent_cnt + 32'd1;
        if (last_flit) begin
          idx <= '0;
          seq <= seq + 32'd1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == ST_GAP)
        gap_cnt <= gap_end ? '0 : gap_cnt + 32'd1;
    end
  end

  a_credit_range: assert property (
    @(posedge clk) disable iff (!rstn)
      credit_cnt <= CW'(CREDITS)
  );

`ifdef INJECTOR_TRACE_EN
  always @(posedge clk) begin
    if (rstn && issue)
      $display("send_pool_%s %b", id, flit);
  end
`endif

endmodule

// File: tb/tb_injector.sv
// tb_injector: directed scoreboard bench for injector
// covering credits, stalls, gaps, reset abort and a full run.
module tb_injector;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic        cu_a, cu_b;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic        a_done, b_done;
  logic [31:0] a_sent, b_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int a_vcnt = 0;
  int ma_seq = 0;
  int ma_idx = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int bcyc[$];

  always #5 clk = ~clk;

  injector #(
    .id("a"), .DW(32), .CREDITS(4),
    .NUM_PKT(198), .PKT_LEN(5), .GAP(0)
  ) u_a (
    .clk(clk), .rstn(rstn), .start(start_a),
    .valid(a_valid), .data(a_data),
    .credit_upd(cu_a), .done(a_done),
    .sent_cnt(a_sent)
  );

  injector #(
    .id("b"), .DW(32), .CREDITS(2),
    .NUM_PKT(3), .PKT_LEN(1), .GAP(2)
  ) u_b (
    .clk(clk), .rstn(rstn), .start(start_b),
    .valid(b_valid), .data(b_data),
    .credit_upd(cu_b), .done(b_done),
    .sent_cnt(b_sent)
  );

  function automatic logic [31:0] mk(
    input int seq, input int idx, input int len
  );
    logic [1:0] t;
    if (len == 1)            t = 2'b11;
    else if (idx == 0)       t = 2'b01;
    else if (idx == len - 1) t = 2'b10;
    else                     t = 2'b00;
    return {t, 14'(seq), 16'(idx)};
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) begin
      qa.push_back(mk(ma_seq, ma_idx, 5));
      if (ma_idx == 4) begin
        ma_idx = 0;
        ma_seq++;
      end else begin
        ma_idx++;
      end
    end
  endtask

  task automatic reset_model();
    qa.delete();
    ma_seq = 0;
    ma_idx = 0;
    a_vcnt = 0;
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (a_valid) begin
      a_vcnt++;
      chk("a_sb_has_entry", 64'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_flit", 64'(a_data), 64'(e));
      end
    end
    if (b_valid) begin
      bcyc.push_back(cyc);
      chk("b_sb_has_entry", 64'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_flit", 64'(b_data), 64'(e));
      end
    end
  endtask

  initial begin
    int first_c;
    int last_c;
    int done_c;
    logic done_at_last;
    logic [31:0] first_d;

    rstn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    cu_a = 1'b0;
    cu_b = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(a_valid), 0);
    chk("rst_data", 64'(a_data), 0);
    chk("rst_done", 64'(a_done), 0);
    chk("rst_sent", 64'(a_sent), 0);
    chk("rst_credit", 64'(u_a.credit_cnt), 4);
    chk("rst_b_valid", 64'(b_valid), 0);
    rstn = 1'b1;
    tick();

    // only the initial credits, no returns
    start_a = 1'b1;
    push_a(4);
    tick();
    start_a = 1'b0;
    chk("start_lat0", 64'(a_valid), 0);
    tick();
    chk("start_lat1", 64'(a_valid), 1);
    chk("first_type", 64'(a_data[31:30]), 1);
    chk("first_idx", 64'(a_data[15:0]), 0);
    repeat (10) tick();
    chk("stall_vcnt", 64'(a_vcnt), 4);
    chk("stall_sent", 64'(a_sent), 4);
    chk("stall_valid", 64'(a_valid), 0);
    chk("stall_credit", 64'(u_a.credit_cnt), 0);

    // one returned credit releases exactly one flit
    cu_a = 1'b1;
    push_a(1);
    tick();
    cu_a = 1'b0;
    chk("upd_lat0", 64'(a_valid), 0);
    chk("upd_credit", 64'(u_a.credit_cnt), 1);
    tick();
    chk("upd_lat1", 64'(a_valid), 1);
    repeat (5) tick();
    chk("upd_vcnt", 64'(a_vcnt), 5);
    chk("upd_sent", 64'(a_sent), 5);

    // return and issue in the same cycle
    cu_a = 1'b1;
    push_a(2);
    tick();
    tick();
    chk("simul_valid", 64'(a_valid), 1);
    chk("simul_credit", 64'(u_a.credit_cnt), 1);
    cu_a = 1'b0;
    tick();
    chk("simul_nogap", 64'(a_valid), 1);
    chk("simul_credit0", 64'(u_a.credit_cnt), 0);
    tick();
    chk("simul_stall", 64'(a_valid), 0);
    chk("simul_sent", 64'(a_sent), 7);
    chk("simul_sb_empty", 64'(qa.size()), 0);

    // one-cycle reset in the middle of packet 1
    rstn = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(a_valid), 0);
    chk("mid_rst_data", 64'(a_data), 0);
    chk("mid_rst_done", 64'(a_done), 0);
    chk("mid_rst_sent", 64'(a_sent), 0);
    chk("mid_rst_credit", 64'(u_a.credit_cnt), 4);
    rstn = 1'b1;
    reset_model();

    // surplus returns while full must not grow the pool
    cu_a = 1'b1;
    repeat (3) tick();
    cu_a = 1'b0;
    chk("sat_credit", 64'(u_a.credit_cnt), 4);
    start_a = 1'b1;
    push_a(4);
    tick();
    start_a = 1'b0;
    repeat (12) tick();
    chk("sat_vcnt", 64'(a_vcnt), 4);
    chk("sat_sent", 64'(a_sent), 4);
    chk("sat_sb_empty", 64'(qa.size()), 0);

    // full run with a credit returned every cycle
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    reset_model();
    cu_a = 1'b1;
    push_a(990);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    first_c = -1;
    last_c = -1;
    done_c = -1;
    done_at_last = 1'b1;
    first_d = '0;
    for (int i = 0; i < 1200 && done_c < 0; i++) begin
      tick();
      if (a_valid) begin
        if (first_c < 0) begin
          first_c = cyc;
          first_d = a_data;
        end
        last_c = cyc;
        done_at_last = a_done;
      end
      if (a_done)
        done_c = cyc;
    end
    cu_a = 1'b0;
    chk("full_done", 64'(a_done), 1);
    chk("full_sent", 64'(a_sent), 990);
    chk("full_vcnt", 64'(a_vcnt), 990);
    chk("full_b2b", 64'(last_c - first_c + 1), 990);
    chk("full_first_type", 64'(first_d[31:30]), 1);
    chk("full_first_idx", 64'(first_d[15:0]), 0);
    chk("full_done_early", 64'(done_at_last), 0);
    chk("full_done_edge", 64'(done_c - last_c), 1);
    chk("full_end_valid", 64'(a_valid), 0);
    chk("full_sb_empty", 64'(qa.size()), 0);

    // single-flit packets with two idle cycles between
    cu_b = 1'b1;
    for (int s = 0; s < 3; s++)
      qb.push_back(mk(s, 0, 1));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 40 && !b_done; i++)
      tick();
    cu_b = 1'b0;
    chk("gap_done", 64'(b_done), 1);
    chk("gap_sent", 64'(b_sent), 3);
    chk("gap_nflits", 64'(bcyc.size()), 3);
    if (bcyc.size() == 3) begin
      chk("gap_01", 64'(bcyc[1] - bcyc[0]), 3);
      chk("gap_12", 64'(bcyc[2] - bcyc[1]), 3);
    end
    chk("gap_sb_empty", 64'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
